// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV32I data-memory responder for the MEM stage
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                         state;
    logic [2:0]                     wait_cnt;
    logic [DEPTH_WORDS-1:0][31:0]   mem;

    logic          valid;
    logic          is_store;
    logic          is_load;
    logic          aligned;
    logic          complete;
    logic [AW-1:0] idx;
    logic [31:0]   cur_word;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_v;
    logic [31:0]   wmask;
    logic [31:0]   wlane;
    logic [31:0]   merged;
    logic          unused_addr;

    // A store wins when both request bits are set.
    assign valid    = mem_read | mem_write;
    assign is_store = mem_write;
    assign is_load  = mem_read & ~mem_write;

    // Upper address bits fold away: the array wraps modulo 4*DEPTH_WORDS.
    assign idx         = addr[AW+1:2];
    assign cur_word    = mem[idx];
    assign unused_addr = ^addr[31:AW+2];

    // Alignment by access size; unlisted load codes behave as LW, unlisted store codes never write.
    always_comb begin
        aligned = 1'b1;
        if (is_store) begin
            case (func3)
                3'b001:  aligned = ~addr[0];
                3'b010:  aligned = (addr[1:0] == 2'b00);
                default: aligned = 1'b1;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b100: aligned = 1'b1;
                3'b001, 3'b101: aligned = ~addr[0];
                default:        aligned = (addr[1:0] == 2'b00);
            endcase
        end
    end

    // Completion is the DONE cycle, or the request cycle itself when there are no wait states.
    assign complete = valid & aligned &
                      ((state == DONE) || ((WAIT_CYCLES == 0) && (state == IDLE)));

    assign stall      = ((WAIT_CYCLES > 0) && (state == IDLE) && valid && aligned) ||
                        (state == BUSY);
    assign misaligned = (state == IDLE) && valid && !aligned;

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (addr[1:0])
            2'b00:   byte_v = cur_word[7:0];
            2'b01:   byte_v = cur_word[15:8];
            2'b10:   byte_v = cur_word[23:16];
            default: byte_v = cur_word[31:24];
        endcase
        half_v = addr[1] ? cur_word[31:16] : cur_word[15:0];
        case (func3)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b100:  load_v = {24'h0, byte_v};
            3'b101:  load_v = {16'h0, half_v};
            default: load_v = cur_word;
        endcase
        rdata = (complete && is_load) ? load_v : 32'h0;
    end

    // Store lane mask and data, merged over the current word so untouched bytes survive.
    always_comb begin
        wmask = 32'h0;
        wlane = 32'h0;
        case (func3)
            3'b000: begin
                wmask = 32'h0000_00FF << {addr[1:0], 3'b000};
                wlane = {4{wdata[7:0]}};
            end
            3'b001: begin
                wmask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wlane = {2{wdata[15:0]}};
            end
            3'b010: begin
                wmask = 32'hFFFF_FFFF;
                wlane = wdata;
            end
            default: begin
                wmask = 32'h0;
                wlane = 32'h0;
            end
        endcase
        merged = (cur_word & ~wmask) | (wlane & wmask);
    end

    // Wait-state sequencer; with one wait state the BUSY phase is skipped entirely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if ((WAIT_CYCLES > 0) && valid && aligned) begin
                        wait_cnt <= 3'(WAIT_CYCLES - 1);
                        state    <= (WAIT_CYCLES == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt <= 3'd1) begin
                        state <= DONE;
                    end
                end
                default: begin
                    wait_cnt <= 3'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Array: cleared by reset, a store commits on the edge closing its completion cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '0;
        end else if (complete && is_store) begin
            mem[idx] <= merged;
        end
    end
endmodule
